fetch_pipe: RTL and testbench

Instruction fetch and pipeline-register stage that feeds the decode/execute control logic. It owns the program counter, drives the synchronous instruction-memory address, and presents the executing instruction (`inst0`/`pc0`) and the write-back instruction (`inst1`/`pc1`). It handles taken-branch/jump redirects with a single injected NOP bubble and freezes on a pipeline stall.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_pipe.sv | 125 ++++++++++++
 tb/tb_fetch_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU front end and control.
//   NOP            - bubble instruction (addi x0,x0,0)
//   RESET_PC       - first fetch address after reset
//   OPC_*          - RV32I major opcodes (inst[6:0])
//   fetch_state_t  - fetch sequencer states
package cpu_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_2000;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pipe.sv
// fetch_pipe: program counter, instruction-BRAM addressing and the
// execute / write-back instruction registers.
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low
//   stall      - freeze PC, sequencer and both instruction registers
//   PCSel      - taken branch/jump request for the instruction in inst0
//   alu_out    - redirect target (bits [1:0] ignored)
//   imem_addr  - byte address to synchronous BRAM (data next cycle)
//   imem_rdata - BRAM read data
//   inst0/pc0  - instruction and PC in execute (combinational)
//   inst1/pc1  - instruction and PC in write-back (registered)
//   pc1_plus4  - pc1 + 4, the JAL/JALR link value (registered)
module fetch_pipe
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSel,
  input  logic [31:0] alu_out,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst0,
  output logic [31:0] pc0,
  output logic [31:0] inst1,
  output logic [31:0] pc1,
  output logic [31:0] pc1_plus4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_x_q, pc_x_d;        // PC of the word now on imem_rdata
  logic [31:0]  target_q, target_d;
  logic [31:0]  inst1_q, inst1_d;
  logic [31:0]  pc1_q, pc1_d;
  logic [31:0]  pc1_plus4_q, pc1_plus4_d;
  logic [31:0]  pc_x_plus4;

  // Target bits [1:0] are architecturally dropped.
  logic unused_alu_bits;
  assign unused_alu_bits = ^alu_out[1:0];

  assign pc_x_plus4 = pc_x_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_x_d    = pc_x_q;
    target_d  = target_q;
    inst0     = NOP;
    pc0       = RESET_PC;
    imem_addr = RESET_PC;

    case (state_q)
      BOOT: begin
        // The first word is in flight; stall cannot hold us here.
        pc_x_d  = RESET_PC;
        state_d = RUN;
      end
      RUN: begin
        inst0 = imem_rdata;
        pc0   = pc_x_q;
        if (stall) begin
          // Re-read the same word so the BRAM output stays valid.
          imem_addr = pc_x_q;
        end else begin
          // The sequential fetch is issued even when redirecting; it is
          // discarded because REDIR shows a NOP instead of imem_rdata.
          // Keeping alu_out out of imem_addr keeps the ALU off the BRAM path.
          imem_addr = pc_x_plus4;
          if (PCSel) begin
            target_d = {alu_out[31:2], 2'b00};
            state_d  = REDIR;
          end else begin
            pc_x_d = pc_x_plus4;
          end
        end
      end
      REDIR: begin
        // PCSel is ignored here: it would belong to the bubble.
        pc0       = target_q;
        imem_addr = target_q;
        if (!stall) begin
          pc_x_d  = target_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_comb begin
    inst1_d     = inst1_q;
    pc1_d       = pc1_q;
    pc1_plus4_d = pc1_plus4_q;
    if (!stall) begin
      inst1_d     = inst0;
      pc1_d       = pc0;
      pc1_plus4_d = pc0 + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      pc_x_q      <= RESET_PC;
      target_q    <= RESET_PC;
      inst1_q     <= NOP;
      pc1_q       <= RESET_PC;
      pc1_plus4_q <= RESET_PC + 32'd4;
    end else begin
      state_q     <= state_d;
      pc_x_q      <= pc_x_d;
      target_q    <= target_d;
      inst1_q     <= inst1_d;
      pc1_q       <= pc1_d;
      pc1_plus4_q <= pc1_plus4_d;
    end
  end

  assign inst1     = inst1_q;
  assign pc1       = pc1_q;
  assign pc1_plus4 = pc1_plus4_q;

endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: self-checking bench for fetch_pipe with a synchronous
// BRAM model (word i holds 32'h1000_0000 + i) and a program-order
// reference model.
module tb_fetch_pipe;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        PCSel;
  logic [31:0] alu_out;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst0, pc0, inst1, pc1, pc1_plus4;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .PCSel      (PCSel),
    .alu_out    (alu_out),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst0      (inst0),
    .pc0        (pc0),
    .inst1      (inst1),
    .pc1        (pc1),
    .pc1_plus4  (pc1_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) imem_rdata <= memf(imem_addr);

  // Reference model: the PC of the instruction being executed, whether
  // the execute slot holds a bubble, and the write-back pair.
  logic [31:0] m_pc, m_wi, m_wp;
  bit          m_bub, m_boot;

  localparam logic [191:0] RESET_VEC =
    {NOP, RESET_PC, NOP, RESET_PC, RESET_PC + 32'd4, RESET_PC};

  function automatic logic [31:0] exp_inst0();
    return m_bub ? NOP : memf(m_pc);
  endfunction

  function automatic logic [191:0] exp_vec();
    logic [31:0] a;
    a = (m_bub || stall) ? m_pc : m_pc + 32'd4;
    return {exp_inst0(), m_pc, m_wi, m_wp, m_wp + 32'd4, a};
  endfunction

  function automatic logic [191:0] dut_vec();
    return {inst0, pc0, inst1, pc1, pc1_plus4, imem_addr};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_bub = 1'b1; m_boot = 1'b1;
    m_wi = NOP; m_wp = RESET_PC;
  endtask

  // Called right after a rising edge with the inputs that edge saw.
  task automatic model_adv();
    if (!stall) begin
      m_wi = exp_inst0();
      m_wp = m_pc;
    end
    if (m_boot) begin
      m_boot = 1'b0;
      m_bub  = 1'b0;
    end else if (!stall) begin
      if (m_bub) m_bub = 1'b0;
      else if (PCSel) begin
        m_bub = 1'b1;
        m_pc  = {alu_out[31:2], 2'b00};
      end else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; PCSel = 1'b0; alu_out = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_values got %h exp %h", dut_vec(), RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      stall = 1'b0; PCSel = 1'b0; alu_out = $urandom;
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL boot_seq c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      if (c == 1) begin
        n_tests++;
        if (inst0 !== 32'h1000_0800 || pc0 !== 32'h2000) begin
          n_fail++;
          $display("FAIL first_inst got %h@%h exp 10000800@00002000", inst0, pc0);
        end
      end
      if (c == 2) begin
        n_tests++;
        if (inst1 !== 32'h1000_0800 || pc1 !== 32'h2000 || inst0 !== 32'h1000_0801) begin
          n_fail++;
          $display("FAIL wb_trail got inst1 %h pc1 %h inst0 %h exp 10000800 00002000 10000801",
                   inst1, pc1, inst0);
        end
      end
      @(posedge clk); model_adv(); @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      stall = 1'b0; PCSel = (c == 3);
      alu_out = (c >= 3) ? 32'h0000_3003 : $urandom;
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL redirect c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      if (c == 3) begin
        n_tests++;
        if (pc0 !== 32'h2008) begin
          n_fail++; $display("FAIL redir_origin got %h exp 00002008", pc0);
        end
      end
      if (c == 4) begin
        n_tests++;
        if (inst0 !== NOP || pc0 !== 32'h3000) begin
          n_fail++; $display("FAIL redir_bubble got %h@%h exp 00000013@00003000", inst0, pc0);
        end
      end
      if (c == 5) begin
        n_tests++;
        if (inst0 !== 32'h1000_0C00 || pc0 !== 32'h3000) begin
          n_fail++; $display("FAIL redir_target got %h@%h exp 10000c00@00003000", inst0, pc0);
        end
      end
      if (c >= 3) begin
        n_tests++;
        if (imem_addr === alu_out) begin
          n_fail++; $display("FAIL addr_not_alu c%0d got %h exp not %h", c, imem_addr, alu_out);
        end
      end
      @(posedge clk); model_adv(); @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [191:0] snap;
    snap = '0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      stall = (c >= 5 && c <= 7); PCSel = 1'b0; alu_out = $urandom;
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      if (c == 5) snap = dut_vec();
      if (c == 6 || c == 7) begin
        n_tests++;
        if (dut_vec() !== snap) begin
          n_fail++; $display("FAIL stall_hold c%0d got %h exp %h", c, dut_vec(), snap);
        end
      end
      if (c == 9) begin
        n_tests++;
        if (pc0 !== 32'h2014 || inst0 !== 32'h1000_0805) begin
          n_fail++; $display("FAIL stall_resume got %h@%h exp 10000805@00002014", inst0, pc0);
        end
      end
      @(posedge clk); model_adv(); @(negedge clk);
    end
  endtask

  task automatic test_stall_pcsel();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      stall   = (c == 2 || c == 3);
      PCSel   = (c >= 2 && c <= 5);
      alu_out = (c == 4) ? 32'h0000_5000 : (c == 5 ? 32'h0000_6000 : 32'h0000_4000);
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_pcsel c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      if (c == 5) begin
        n_tests++;
        if (inst0 !== NOP || pc0 !== 32'h5000) begin
          n_fail++; $display("FAIL sp_bubble got %h@%h exp 00000013@00005000", inst0, pc0);
        end
      end
      if (c == 6) begin
        n_tests++;
        if (inst0 !== 32'h1000_1400 || pc0 !== 32'h5000) begin
          n_fail++; $display("FAIL sp_single_bubble got %h@%h exp 10001400@00005000", inst0, pc0);
        end
      end
      @(posedge clk); model_adv(); @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      stall = 1'b0; PCSel = (c == 1); alu_out = 32'hFFFF_FFFF;
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      if (c == 4) begin
        n_tests++;
        if (pc0 !== 32'h0 || pc1 !== 32'hFFFF_FFFC || pc1_plus4 !== 32'h0) begin
          n_fail++;
          $display("FAIL wrap_pc got pc0 %h pc1 %h p4 %h exp 00000000 fffffffc 00000000",
                   pc0, pc1, pc1_plus4);
        end
      end
      @(posedge clk); model_adv(); @(negedge clk);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      stall   = ($urandom_range(3) == 0);
      PCSel   = ($urandom_range(4) == 0);
      alu_out = $urandom;
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c%0d st%0b ps%0b got %h exp %h", c, stall, PCSel,
                 dut_vec(), exp_vec());
      end
      @(posedge clk); model_adv(); @(negedge clk);
    end
  endtask

  task automatic test_reset_redir();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      stall = 1'b0; PCSel = (c == 1); alu_out = 32'h0000_7000;
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL pre_reset c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      if (c < 2) begin
        @(posedge clk); model_adv(); @(negedge clk);
      end
    end
    // In the bubble now; reset mid-phase, no clock edge before checking.
    PCSel = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL async_reset got %h exp %h", dut_vec(), RESET_VEC);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      stall = 1'b0; PCSel = 1'b0; alu_out = $urandom;
      #1;
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset c%0d got %h exp %h", c, dut_vec(), exp_vec());
      end
      if (c == 1) begin
        n_tests++;
        if (pc0 !== RESET_PC || inst0 !== 32'h1000_0800) begin
          n_fail++; $display("FAIL no_stale_redir got %h@%h exp 10000800@00002000", inst0, pc0);
        end
      end
      @(posedge clk); model_adv(); @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; PCSel = 1'b0; alu_out = '0;
    model_reset();
    test_reset();
    test_redirect();
    test_stall();
    test_stall_pcsel();
    test_wrap();
    test_random();
    test_reset_redir();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
